// File: rtl/rpn_stack_driver.sv
// rpn_stack_driver: evaluates an RPN token stream on an external 23-bit stack.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   tok_valid/tok_ready  : token handshake; accepted when both are 1 at a rising edge
//   tok_is_op            : 1 = operator (code in tok_data[1:0]), 0 = operand
//   tok_data             : operand value or operator code
//   tok_last             : token ends the expression
//   stk_in               : data written to the stack on stk_push
//   stk_push/stk_pop     : one-cycle stack commands
//   stk_top              : unused stack command, held 0
//   stk_clr              : one-cycle stack clear
//   stk_out              : stack read data, valid the cycle after stk_pop
//   res_valid/res        : result pulse and held result value
//   err                  : high while the block is draining an erroneous expression
module rpn_stack_driver (
   input  logic        clk,
   input  logic        rst,
   input  logic        tok_valid,
   output logic        tok_ready,
   input  logic        tok_is_op,
   input  logic [22:0] tok_data,
   input  logic        tok_last,
   output logic [22:0] stk_in,
   output logic        stk_push,
   output logic        stk_pop,
   output logic        stk_top,
   output logic        stk_clr,
   input  logic [22:0] stk_out,
   output logic        res_valid,
   output logic [22:0] res,
   output logic        err
);

   typedef enum logic [3:0] {
      IDLE, PUSH, POP1, POP2, CALC, PUSHR, FIN, GET, ERR, CLR
   } state_t;

   localparam logic [7:0] DEPTH_MAX = 8'd128;

   state_t      state_q, state_d;
   logic        tok_ready_q, tok_ready_d;
   logic [22:0] stk_in_q, stk_in_d;
   logic        stk_push_q, stk_push_d;
   logic        stk_pop_q, stk_pop_d;
   logic        stk_clr_q, stk_clr_d;
   logic [22:0] res_q, res_d;
   logic        res_valid_q, res_valid_d;
   logic        err_q, err_d;
   logic [7:0]  depth_q, depth_d;
   logic [1:0]  op_q, op_d;
   logic        last_q, last_d;
   logic [22:0] b_q, b_d;
   logic        accept;

   assign accept = tok_valid && tok_ready_q;

   always_comb begin
      state_d     = state_q;
      stk_in_d    = stk_in_q;
      res_d       = res_q;
      op_d        = op_q;
      last_d      = last_q;
      b_d         = b_q;
      // Depth follows the pulses actually on the stack port this cycle.
      depth_d     = depth_q + 8'(stk_push_q) - 8'(stk_pop_q);
      res_valid_d = (state_q == GET);

      case (state_q)
         IDLE: begin
            if (accept) begin
               last_d = tok_last;
               if (!tok_is_op) begin
                  if (depth_q == DEPTH_MAX) begin
                     state_d = ERR;
                  end else begin
                     stk_in_d = tok_data;
                     state_d  = PUSH;
                  end
               end else begin
                  op_d = tok_data[1:0];
                  if (depth_q < 8'd2 || tok_data[1:0] == 2'b11) state_d = ERR;
                  else                                           state_d = POP1;
               end
            end
         end
         PUSH, PUSHR: state_d = last_q ? FIN : IDLE;
         POP1:        state_d = POP2;
         POP2: begin
            b_d     = stk_out;
            state_d = CALC;
         end
         CALC: begin
            // stk_out now holds a (the deeper operand); arithmetic wraps at 23 bits.
            case (op_q)
               2'b00:   stk_in_d = stk_out + b_q;
               2'b01:   stk_in_d = stk_out - b_q;
               default: stk_in_d = stk_out * b_q;
            endcase
            state_d = PUSHR;
         end
         FIN:  state_d = (depth_q == 8'd1) ? GET : ERR;
         GET: begin
            res_d   = stk_out;
            state_d = IDLE;
         end
         ERR: begin
            // last_q set means the expression already ended with the faulty
            // token (or at FIN), so there is nothing left to drain.
            if (last_q || (accept && tok_last)) state_d = CLR;
         end
         CLR: begin
            depth_d = '0;
            // Right after reset no clear pulse has gone out yet; stay one more
            // cycle so exactly one stk_clr is issued.
            if (stk_clr_q) state_d = IDLE;
         end
         default: state_d = CLR;
      endcase

      // Moore-style registered outputs decoded from the next state.
      stk_push_d  = (state_d == PUSH) || (state_d == PUSHR);
      stk_pop_d   = (state_d == POP1) || (state_d == POP2) ||
                    ((state_d == FIN) && (depth_d == 8'd1));
      stk_clr_d   = (state_d == CLR) && !stk_clr_q;
      err_d       = (state_d == ERR);
      tok_ready_d = (state_d == IDLE) || ((state_d == ERR) && !last_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLR;
         tok_ready_q <= 1'b0;
         stk_in_q    <= '0;
         stk_push_q  <= 1'b0;
         stk_pop_q   <= 1'b0;
         stk_clr_q   <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         depth_q     <= '0;
         op_q        <= '0;
         last_q      <= 1'b0;
         b_q         <= '0;
      end else begin
         state_q     <= state_d;
         tok_ready_q <= tok_ready_d;
         stk_in_q    <= stk_in_d;
         stk_push_q  <= stk_push_d;
         stk_pop_q   <= stk_pop_d;
         stk_clr_q   <= stk_clr_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
         depth_q     <= depth_d;
         op_q        <= op_d;
         last_q      <= last_d;
         b_q         <= b_d;
      end
   end

   assign tok_ready = tok_ready_q;
   assign stk_in    = stk_in_q;
   assign stk_push  = stk_push_q;
   assign stk_pop   = stk_pop_q;
   assign stk_top   = 1'b0;
   assign stk_clr   = stk_clr_q;
   assign res       = res_q;
   assign res_valid = res_valid_q;
   assign err       = err_q;

endmodule

// File: doc/rpn_stack_driver.md
RPN_STACK_DRIVER -- requirements
Module: rpn_stack_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port tok_valid, input, 1 bit: a token is offered.
REQ-004 SHALL have port tok_ready, output, 1 bit: the block accepts the offered token.
REQ-005 SHALL have port tok_is_op, input, 1 bit: 1 means operator token; 0 means operand token.
REQ-006 SHALL have port tok_data, input, 23 bits: operand value, or operator code in bits [1:0].
REQ-007 SHALL have port tok_last, input, 1 bit: the token is the last token of the expression.
REQ-008 SHALL have port stk_in, output, 23 bits: data to the stack.
REQ-009 SHALL have ports stk_push and stk_pop, outputs, 1 bit each: stack commands, one-cycle pulses.
REQ-010 SHALL have port stk_top, output, 1 bit: held 0 in all states.
REQ-011 SHALL have port stk_clr, output, 1 bit: stack reset pulse.
REQ-012 SHALL have port stk_out, input, 23 bits: stack read data, valid the cycle after a stk_pop pulse.
REQ-013 SHALL have ports res_valid and res, outputs, 1 bit and 23 bits: expression result.
REQ-014 SHALL have port err, output, 1 bit: expression error.

Function
REQ-015 SHALL accept a token only at a rising edge where tok_valid=1 and tok_ready=1.
REQ-016 SHALL assert tok_ready only in states IDLE and ERR.
REQ-017 SHALL keep an internal depth counter (0..128) that mirrors stack occupancy: +1 on each stk_push cycle, -1 on each stk_pop cycle.
REQ-018 SHALL, in IDLE, on accepting an operand: register stk_in=tok_data, latch tok_last, then go to PUSH.
- Exception: if depth=128, go to ERR instead.
REQ-019 SHALL, in IDLE, on accepting an operator: latch the op code and tok_last, then go to POP1.
- Exception: if depth<2 or op code=11, go to ERR instead.
REQ-020 SHALL, in PUSH: stk_push=1 for one cycle, then go to FIN if the latched last=1, else to IDLE.
REQ-021 SHALL, in POP1: stk_pop=1, then go to POP2.
REQ-022 SHALL, in POP2: capture b=stk_out, stk_pop=1, then go to CALC.
REQ-023 SHALL, in CALC: capture a=stk_out and register stk_in = a op b, then go to PUSHR.
REQ-024 SHALL, in PUSHR: stk_push=1, then go to FIN if the latched last=1, else to IDLE.
REQ-025 SHALL use op codes 00 = a+b, 01 = a-b, 10 = a*b (low 23 bits of the product); all arithmetic is modulo 2^23, unsigned.
REQ-026 SHALL, in FIN:
- if depth≠1, go to ERR;
- else stk_pop=1, then go to GET.
REQ-027 SHALL, in GET: res=stk_out, res_valid=1 for exactly one cycle, then go to IDLE with depth=0.
REQ-028 SHALL hold res stable until the next res_valid pulse.
REQ-029 SHALL, on entering ERR, set err=1 and keep it at 1 while in ERR.
- The token that triggered the error SHALL count as consumed.
REQ-030 SHALL, in ERR, accept and discard tokens until a token with tok_last=1 is accepted, then go to CLR.
- If the erroring token itself had tok_last=1, go to CLR directly.
REQ-031 SHALL, in CLR: stk_clr=1 for one cycle, depth=0, err=0, then go to IDLE.
REQ-032 SHALL drive stk_push, stk_pop and stk_clr as registered one-cycle pulses, mutually exclusive.
REQ-033 SHALL never issue stk_push when depth=128 or stk_pop when depth=0.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, clear the following to 0:
- tok_ready, stk_in, stk_push, stk_pop, stk_top, res, res_valid, err, depth.
REQ-035 SHALL enter state CLR after reset so that one stk_clr pulse follows reset release, then go to IDLE.
REQ-036 SHALL take rst asserted mid-operation (any state) over all other activity; partial results are discarded.

Verification
REQ-037 SHALL pass: tokens 3, 4, +(00, last) -> res=7 with one res_valid pulse; err=0; depth=0.
REQ-038 SHALL pass: tokens 5, 7, -(01, last) -> res=0x7FFFFE; tokens 10, 3, - -> res=7.
REQ-039 SHALL pass: tokens 2, 3, 4, *, +(last) -> res=14; a 0x400000 * 2 expression -> res=0.
REQ-040 SHALL pass: + as the first token -> err=1; following tokens are drained until tok_last; one stk_clr pulse; err=0; then 1(last) -> res=1.
REQ-041 SHALL pass: 129 operands -> err on the 129th, no 129th stk_push; tokens 1, 2(last) -> err (depth=2 at FIN).
REQ-042 SHALL pass: rst asserted during PUSHR -> all outputs 0 next cycle, one stk_clr pulse after release, then tok_ready=1.
